// File: rtl/div_bus_pkg.sv
// -----------------------------------------------------------------------------
// div_bus_pkg
// Shared definitions for the 8-bit bus-interfaced divider. This package is
// used by the bus initiator (div_bus_master) and by the divider's bus slave
// wrapper.
//   - Register map addresses (ADDR_A_LO .. ADDR_R_HI)
//   - CTRL start command byte, STATUS ready bit position
//   - Initiator FSM state enum
// -----------------------------------------------------------------------------
package div_bus_pkg;

  localparam int ADDR_A_LO  = 0;
  localparam int ADDR_A_HI  = 1;
  localparam int ADDR_B_LO  = 2;
  localparam int ADDR_B_HI  = 3;
  localparam int ADDR_CTRL  = 4;
  localparam int ADDR_STAT  = 5;
  localparam int ADDR_Q_LO  = 6;
  localparam int ADDR_Q_HI  = 7;
  localparam int ADDR_R_LO  = 8;
  localparam int ADDR_R_HI  = 9;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam int STATUS_READY_BIT  = 0;

  // Write phase (W_*), status poll (P_*), then read-back of the results as
  // read-strobe / capture pairs (R_* / C_*).
  typedef enum logic [4:0] {
    S_IDLE,
    S_W_AL, S_W_AH, S_W_BL, S_W_BH, S_W_GO,
    S_P_RD, S_P_CAP,
    S_R_QL, S_C_QL, S_R_QH, S_C_QH,
    S_R_RL, S_C_RL, S_R_RH, S_C_RH,
    S_RESP
  } state_t;

endpackage

// File: rtl/div_bus_master_if.sv
// -----------------------------------------------------------------------------
// div_bus_master_if
// This interface groups the host request/response handshakes and the 8-bit
// register bus of the divider initiator.
//   req_*     : host request (valid/ready, 16-bit A and B)
//   rsp_*     : response (valid/ready, Q, R, divide-by-zero and timeout flags)
//   bus_*     : register bus (address, write strobe + data, read strobe,
//               read data returned the cycle after bus_rd)
// Modports:
//   master : the initiator's view (drives req_ready, rsp_*, bus strobes)
//   slave  : the view of the host and the bus slave (drives requests,
//            rsp_ready and bus_rdata)
// -----------------------------------------------------------------------------
interface div_bus_master_if #(
  parameter int ADDR_W = 4
);

  logic              req_valid;
  logic              req_ready;
  logic [15:0]       req_a;
  logic [15:0]       req_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_q;
  logic [15:0]       rsp_r;
  logic              rsp_dz;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wr;
  logic [7:0]        bus_wdata;
  logic              bus_rd;
  logic [7:0]        bus_rdata;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, bus_rdata,
    output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_timeout,
           bus_addr, bus_wr, bus_wdata, bus_rd
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, bus_rdata,
    input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_timeout,
           bus_addr, bus_wr, bus_wdata, bus_rd
  );

endinterface

// File: rtl/div_bus_master.sv
// -----------------------------------------------------------------------------
// div_bus_master
// This module is the bus initiator for the 8-bit bus-interfaced divider. It
// accepts one A/B request, writes the operands and a start command byte by
// byte, and polls STATUS until the divider reports ready. It then reads Q and R
// back and holds them on the response port until the consumer accepts them.
// When B is zero, no bus traffic is issued and an immediate divide-by-zero
// response is returned. If ready is not seen within POLL_MAX status reads, a
// timeout response is returned.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : div_bus_master_if.master (request, response and register bus)
// Parameters:
//   POLL_MAX : status reads (1..255) before giving up
//   ADDR_W   : bus address width
// -----------------------------------------------------------------------------
module div_bus_master
  import div_bus_pkg::*;
#(
  parameter int POLL_MAX = 64,
  parameter int ADDR_W   = 4
) (
  input  logic clk,
  input  logic rst,
  div_bus_master_if.master bus
);

  state_t            state;
  state_t            next_state;

  logic [15:0]       a_reg;
  logic [15:0]       b_reg;
  logic [7:0]        poll_cnt;
  logic [15:0]       q_reg;
  logic [15:0]       r_reg;
  logic              dz_reg;
  logic              to_reg;

  logic              accept;
  logic              status_ready;
  logic              poll_last;

  logic [ADDR_W-1:0] addr_c;
  logic              wr_c;
  logic              rd_c;
  logic [7:0]        wdata_c;

  assign accept       = (state == S_IDLE) && bus.req_valid;
  assign status_ready = bus.bus_rdata[STATUS_READY_BIT];
  // The current poll is the last one allowed if one more failed read would
  // bring the count up to POLL_MAX.
  assign poll_last    = (({1'b0, poll_cnt} + 9'd1) >= 9'(POLL_MAX));

  // State register. Because the bus strobes decode directly from the state,
  // an asynchronous reset removes them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus-strobe decode. Only one strobe is active per state,
  // so bus_wr and bus_rd can never be asserted together.
  always_comb begin
    next_state = state;
    addr_c     = '0;
    wr_c       = 1'b0;
    rd_c       = 1'b0;
    wdata_c    = 8'h00;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          next_state = (bus.req_b == 16'd0) ? S_RESP : S_W_AL;
        end
      end
      S_W_AL: begin
        wr_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_A_LO);
        wdata_c    = a_reg[7:0];
        next_state = S_W_AH;
      end
      S_W_AH: begin
        wr_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_A_HI);
        wdata_c    = a_reg[15:8];
        next_state = S_W_BL;
      end
      S_W_BL: begin
        wr_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_B_LO);
        wdata_c    = b_reg[7:0];
        next_state = S_W_BH;
      end
      S_W_BH: begin
        wr_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_B_HI);
        wdata_c    = b_reg[15:8];
        next_state = S_W_GO;
      end
      S_W_GO: begin
        wr_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_CTRL);
        wdata_c    = CMD_START;
        next_state = S_P_RD;
      end
      S_P_RD: begin
        rd_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_STAT);
        next_state = S_P_CAP;
      end
      S_P_CAP: begin
        if (status_ready) begin
          next_state = S_R_QL;
        end else if (poll_last) begin
          next_state = S_RESP;
        end else begin
          next_state = S_P_RD;
        end
      end
      S_R_QL: begin
        rd_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_Q_LO);
        next_state = S_C_QL;
      end
      S_C_QL: next_state = S_R_QH;
      S_R_QH: begin
        rd_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_Q_HI);
        next_state = S_C_QH;
      end
      S_C_QH: next_state = S_R_RL;
      S_R_RL: begin
        rd_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_R_LO);
        next_state = S_C_RL;
      end
      S_C_RL: next_state = S_R_RH;
      S_R_RH: begin
        rd_c       = 1'b1;
        addr_c     = ADDR_W'(ADDR_R_HI);
        next_state = S_C_RH;
      end
      S_C_RH: next_state = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand, poll counter and result registers. The results are preloaded at
  // accept (divide-by-zero answer, or zeros), so a timeout only needs to set
  // its flag. A capture state fills one result byte from the read data that
  // follows the previous strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= 16'h0000;
      b_reg    <= 16'h0000;
      poll_cnt <= 8'h00;
      q_reg    <= 16'h0000;
      r_reg    <= 16'h0000;
      dz_reg   <= 1'b0;
      to_reg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_reg    <= bus.req_a;
            b_reg    <= bus.req_b;
            poll_cnt <= 8'h00;
            to_reg   <= 1'b0;
            if (bus.req_b == 16'd0) begin
              dz_reg <= 1'b1;
              q_reg  <= 16'hFFFF;
              r_reg  <= bus.req_a;
            end else begin
              dz_reg <= 1'b0;
              q_reg  <= 16'h0000;
              r_reg  <= 16'h0000;
            end
          end
        end
        S_P_CAP: begin
          if (!status_ready) begin
            poll_cnt <= poll_cnt + 8'd1;
            if (poll_last) begin
              to_reg <= 1'b1;
              q_reg  <= 16'h0000;
              r_reg  <= 16'h0000;
            end
          end
        end
        S_C_QL: q_reg[7:0]  <= bus.bus_rdata;
        S_C_QH: q_reg[15:8] <= bus.bus_rdata;
        S_C_RL: r_reg[7:0]  <= bus.bus_rdata;
        S_C_RH: r_reg[15:8] <= bus.bus_rdata;
        S_RESP: begin
          if (bus.rsp_ready) begin
            dz_reg <= 1'b0;
            to_reg <= 1'b0;
            q_reg  <= 16'h0000;
            r_reg  <= 16'h0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_q       = q_reg;
  assign bus.rsp_r       = r_reg;
  assign bus.rsp_dz      = dz_reg;
  assign bus.rsp_timeout = to_reg;
  assign bus.bus_addr    = addr_c;
  assign bus.bus_wr      = wr_c;
  assign bus.bus_wdata   = wdata_c;
  assign bus.bus_rd      = rd_c;

endmodule

// File: tb/tb_div_bus_master.sv
// -----------------------------------------------------------------------------
// tb_div_bus_master
// This is a directed-vector bench for div_bus_master. It includes a behavioural
// register-bus slave that has a programmable status-ready delay. Each request
// pushes its expected bus writes and its expected response into queues. Monitor
// processes pop from these queues and compare on every bus write and on every
// response handshake.
// -----------------------------------------------------------------------------
module tb_div_bus_master;

  localparam int POLL_MAX = 4;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        to;
  } rsp_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_bus_master_if #(.ADDR_W(4)) bif ();

  div_bus_master #(
    .POLL_MAX (POLL_MAX),
    .ADDR_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  rsp_t        exp_q[$];
  wr_t         wr_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          strobe_cnt = 0;
  int          status_reads = 0;
  int          total_reads = 0;
  int          since_go = 0;
  bit          both_seen = 1'b0;
  int          ready_after = 0;
  logic [15:0] slave_q = 16'h0000;
  logic [15:0] slave_r = 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    n_total++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave. Read data is returned on the cycle after the strobe.
  // STATUS becomes ready on read number ready_after after the start command;
  // a value of 0 means it never becomes ready.
  always @(posedge clk) begin
    if (bif.bus_wr && bif.bus_addr == 4'd4 && bif.bus_wdata == 8'h01) since_go <= 0;
    if (bif.bus_rd) begin
      total_reads <= total_reads + 1;
      case (bif.bus_addr)
        4'd5: begin
          status_reads  <= status_reads + 1;
          since_go      <= since_go + 1;
          bif.bus_rdata <= {7'd0, (ready_after != 0 && since_go + 1 >= ready_after)};
        end
        4'd6:    bif.bus_rdata <= slave_q[7:0];
        4'd7:    bif.bus_rdata <= slave_q[15:8];
        4'd8:    bif.bus_rdata <= slave_r[7:0];
        4'd9:    bif.bus_rdata <= slave_r[15:8];
        default: bif.bus_rdata <= 8'h00;
      endcase
    end
  end

  // Monitor: sample away from the active edge and check bus writes and
  // response handshakes against the scoreboard queues.
  always @(negedge clk) begin
    wr_t  w;
    rsp_t e;
    if (!rst) begin
      if (bif.bus_wr && bif.bus_rd) both_seen <= 1'b1;
      if (bif.bus_wr || bif.bus_rd) strobe_cnt <= strobe_cnt + 1;
      if (bif.bus_wr) begin
        if (wr_q.size() == 0) begin
          n_total++;
          $display("[TB] FAIL unexpected_write: addr %0h data %0h, expected none", bif.bus_addr, bif.bus_wdata);
        end else begin
          w = wr_q.pop_front();
          checkOutput("wr_addr", 32'(bif.bus_addr), 32'(w.addr));
          checkOutput("wr_data", 32'(bif.bus_wdata), 32'(w.data));
        end
      end
      if (bif.rsp_valid && bif.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("[TB] FAIL unexpected_rsp: q %0h r %0h, expected none", bif.rsp_q, bif.rsp_r);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_q", 32'(bif.rsp_q), 32'(e.q));
          checkOutput("rsp_r", 32'(bif.rsp_r), 32'(e.r));
          checkOutput("rsp_dz", 32'(bif.rsp_dz), 32'(e.dz));
          checkOutput("rsp_timeout", 32'(bif.rsp_timeout), 32'(e.to));
        end
      end
    end
  end

  // Program the slave, queue the expected writes and response, then perform
  // the request handshake. acc_cyc records the cycle of the accept edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int rdy,
                               input logic [15:0] sq, input logic [15:0] sr, input bit expect_rsp,
                               input logic [15:0] eq, input logic [15:0] er, input logic edz,
                               input logic eto);
    int n;
    ready_after = rdy;
    slave_q     = sq;
    slave_r     = sr;
    if (b != 16'd0) begin
      wr_q.push_back({4'd0, a[7:0]});
      wr_q.push_back({4'd1, a[15:8]});
      wr_q.push_back({4'd2, b[7:0]});
      wr_q.push_back({4'd3, b[15:8]});
      wr_q.push_back({4'd4, 8'h01});
    end
    if (expect_rsp) exp_q.push_back({eq, er, edz, eto});
    @(posedge clk);
    #1;
    bif.req_valid = 1'b1;
    bif.req_a     = a;
    bif.req_b     = b;
    n = 0;
    @(negedge clk);
    while (!bif.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bif.req_ready) failNow("accept");
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    bif.req_valid = 1'b0;
    bif.req_a     = 16'h0000;
    bif.req_b     = 16'h0000;
  endtask

  task automatic waitValid(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bif.rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bif.rsp_valid) begin
      failNow("rsp_valid");
      lat = -1;
    end else begin
      lat = cyc - acc_cyc + 1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) failNow(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int s0;
    int t0;
    int n;
    rst           = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_a     = 16'h0000;
    bif.req_b     = 16'h0000;
    bif.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(bif.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    checkOutput("rst_bus_wr", 32'(bif.bus_wr), 32'd0);
    checkOutput("rst_bus_rd", 32'(bif.bus_rd), 32'd0);
    checkOutput("rst_bus_addr", 32'(bif.bus_addr), 32'd0);
    checkOutput("rst_bus_wdata", 32'(bif.bus_wdata), 32'd0);
    checkOutput("rst_rsp_q", 32'(bif.rsp_q), 32'd0);
    checkOutput("rst_rsp_r", 32'(bif.rsp_r), 32'd0);
    checkOutput("rst_rsp_dz", 32'(bif.rsp_dz), 32'd0);
    checkOutput("rst_rsp_timeout", 32'(bif.rsp_timeout), 32'd0);
    rst = 1'b0;

    $display("[TB] case 1: 25/5, ready on third poll");
    s0 = status_reads;
    applyStimulus(16'd25, 16'd5, 3, 16'd5, 16'd0, 1'b1, 16'd5, 16'd0, 1'b0, 1'b0);
    waitValid(lat);
    checkOutput("t1_latency", 32'(lat), 32'd20);
    waitDrain("t1_drain");
    checkOutput("t1_status_reads", 32'(status_reads - s0), 32'd3);

    $display("[TB] case 2: -50/7");
    applyStimulus(16'hFFCE, 16'd7, 1, 16'hFFF9, 16'hFFFF, 1'b1, 16'hFFF9, 16'hFFFF, 1'b0, 1'b0);
    waitValid(lat);
    checkOutput("t2_latency", 32'(lat), 32'd16);
    waitDrain("t2_drain");

    $display("[TB] case 3: 23/0");
    s0 = strobe_cnt;
    applyStimulus(16'd23, 16'd0, 1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'd23, 1'b1, 1'b0);
    waitValid(lat);
    checkOutput("t3_latency", 32'(lat), 32'd1);
    waitDrain("t3_drain");
    checkOutput("t3_strobes", 32'(strobe_cnt - s0), 32'd0);

    $display("[TB] case 4: 100/-25, slave never ready");
    s0 = status_reads;
    t0 = total_reads;
    applyStimulus(16'd100, 16'hFFE7, 0, 16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    waitValid(lat);
    checkOutput("t4_latency", 32'(lat), 32'd14);
    waitDrain("t4_drain");
    checkOutput("t4_status_reads", 32'(status_reads - s0), 32'd4);
    checkOutput("t4_total_reads", 32'(total_reads - t0), 32'd4);

    $display("[TB] case 5: response back-pressure");
    bif.rsp_ready = 1'b0;
    applyStimulus(16'd25, 16'd5, 3, 16'd5, 16'd0, 1'b1, 16'd5, 16'd0, 1'b0, 1'b0);
    waitValid(lat);
    bif.req_valid = 1'b1;
    bif.req_a     = 16'd77;
    bif.req_b     = 16'd3;
    for (int i = 0; i < 6; i++) begin
      checkOutput("t5_hold_valid", 32'(bif.rsp_valid), 32'd1);
      checkOutput("t5_hold_q", 32'(bif.rsp_q), 32'd5);
      checkOutput("t5_hold_r", 32'(bif.rsp_r), 32'd0);
      checkOutput("t5_req_ready", 32'(bif.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    bif.req_a     = 16'h0000;
    bif.req_b     = 16'h0000;
    bif.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_req_ready_after", 32'(bif.req_ready), 32'd1);
    checkOutput("t5_valid_after", 32'(bif.rsp_valid), 32'd0);
    checkOutput("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] case 6: reset during second poll");
    applyStimulus(16'h1111, 16'd3, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    n  = 0;
    s0 = 0;
    while (s0 < 2 && n < 200) begin
      @(negedge clk);
      if (bif.bus_rd && bif.bus_addr == 4'd5) s0++;
      n++;
    end
    if (s0 < 2) failNow("t6_second_poll");
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_bus_rd", 32'(bif.bus_rd), 32'd0);
    checkOutput("t6_bus_wr", 32'(bif.bus_wr), 32'd0);
    checkOutput("t6_bus_addr", 32'(bif.bus_addr), 32'd0);
    checkOutput("t6_req_ready", 32'(bif.req_ready), 32'd1);
    checkOutput("t6_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd0, 16'd8, 1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    waitValid(lat);
    checkOutput("t6_latency", 32'(lat), 32'd16);
    waitDrain("t6_drain");
    checkOutput("t6_writes_done", 32'(wr_q.size()), 32'd0);

    checkOutput("strobe_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
